// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the pushbutton debouncer:
//   - btn_state_e : per-button FSM state encoding
//   - CNT_W       : width of the per-button millisecond counter
//   - state_level : debounced level implied by a state
// -----------------------------------------------------------------------------
package btn_pkg;

    localparam int CNT_W = 8;

    // Both "HI" states have bit 1 set, so the debounced level is simply bit 1
    // of the state. That makes the level glitch-free even though it is decoded.
    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } btn_state_e;

    function automatic logic state_level(input btn_state_e st);
        return (st == IDLE_HI) || (st == WAIT_LO);
    endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// -----------------------------------------------------------------------------
// debounce_cell
// Debounces one button: a 2-flop synchroniser, optional inversion, and a
// four-state FSM that accepts a new level only after it has been stable for
// DEB_MS consecutive ticks.
//   clk           : system clock
//   rst_n         : asynchronous active-low reset
//   tick          : one-cycle 1 ms time-base strobe
//   raw           : raw, asynchronous, bouncing button input
//   state         : current FSM state (debug visibility, level is decoded from it)
//   press_pulse   : one-cycle pulse on an accepted 0->1 transition
//   release_pulse : one-cycle pulse on an accepted 1->0 transition
// -----------------------------------------------------------------------------
module debounce_cell
    import btn_pkg::*;
#(
    parameter int DEB_MS = 20,
    parameter bit INV_IN = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       raw,
    output btn_state_e state,
    output logic       press_pulse,
    output logic       release_pulse
);

    // Acceptance happens when the counter already holds DEB_MS-1 and one more
    // tick arrives, so the counter never reaches DEB_MS and never wraps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_MS - 1);

    logic             raw_meta;
    logic             raw_sync;
    logic             s;
    btn_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             press_nxt;
    logic             release_nxt;

    // State register, synchroniser and registered pulse outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_meta      <= 1'b0;
            raw_sync      <= 1'b0;
            state         <= IDLE_LO;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            raw_meta      <= raw;
            raw_sync      <= raw_meta;
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

    assign s = raw_sync ^ INV_IN;

    // Next-state logic. In the WAIT states the bounce test comes before the
    // tick test, so a bounce coinciding with a tick cancels the pending change.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE_LO: begin
                if (s) begin
                    state_nxt = WAIT_HI;
                    cnt_nxt   = '0;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_nxt = IDLE_LO;
                    cnt_nxt   = '0;
                end else if (tick) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = IDLE_HI;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            IDLE_HI: begin
                if (!s) begin
                    state_nxt = WAIT_LO;
                    cnt_nxt   = '0;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_nxt = IDLE_HI;
                    cnt_nxt   = '0;
                end else if (tick) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = IDLE_LO;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE_LO;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic: an acceptance is a WAIT -> opposite IDLE transition.
    // These are registered above so they line up with the level change.
    always_comb begin
        press_nxt   = (state == WAIT_HI) && (state_nxt == IDLE_HI);
        release_nxt = (state == WAIT_LO) && (state_nxt == IDLE_LO);
    end

endmodule

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Debounces N_BTN pushbuttons using the 1 ms square wave as a time base.
//   clk         : system clock, all state on its rising edge
//   rst_n       : asynchronous active-low reset
//   clk_1ms     : 1 ms square wave, sampled as data (never used as a clock)
//   btn_raw     : raw bouncing buttons, asynchronous to clk
//   btn_level   : debounced level per button
//   btn_press   : one-cycle pulse per accepted 0->1 transition
//   btn_release : one-cycle pulse per accepted 1->0 transition
//   tick_1ms    : one-cycle pulse per rising edge of clk_1ms
// -----------------------------------------------------------------------------
module btn_debounce
    import btn_pkg::*;
#(
    parameter int N_BTN  = 4,
    parameter int DEB_MS = 20,
    parameter bit INV_IN = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_1ms,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             tick_1ms
);

    logic ms_meta;
    logic ms_sync;
    logic ms_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_meta <= 1'b0;
            ms_sync <= 1'b0;
            ms_prev <= 1'b0;
        end else begin
            ms_meta <= clk_1ms;
            ms_sync <= ms_meta;
            ms_prev <= ms_sync;
        end
    end

    // Rising edges only; falling edges of the square wave are ignored.
    assign tick_1ms = ms_sync & ~ms_prev;

    btn_state_e cell_state [N_BTN];

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_cell #(
            .DEB_MS (DEB_MS),
            .INV_IN (INV_IN)
        ) u_cell (
            .clk           (clk),
            .rst_n         (rst_n),
            .tick          (tick_1ms),
            .raw           (btn_raw[i]),
            .state         (cell_state[i]),
            .press_pulse   (btn_press[i]),
            .release_pulse (btn_release[i])
        );

        assign btn_level[i] = state_level(cell_state[i]);
    end

endmodule

// File: tb/tb_btn_debounce.sv
module tb_btn_debounce;

    localparam int N       = 4;
    localparam int DEB     = 3;
    localparam int PER     = 20;          // clk_1ms period in clk cycles
    localparam int TICK_PH = PER / 2 + 2; // tick visible 2 clk after the rise is driven

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic rst_n   = 1'b1;
    logic clk_1ms = 1'b0;

    always #5 clk = ~clk;

    // ---------------- DUT (DEB_MS = 3) ----------------
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level, btn_press, btn_release;
    logic         tick_1ms;

    btn_debounce #(.N_BTN(N), .DEB_MS(DEB), .INV_IN(1'b0)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_1ms     (clk_1ms),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .tick_1ms    (tick_1ms)
    );

    // ---------------- DUT (DEB_MS = 1, boundary) ----------------
    logic [N-1:0] raw1 = '0;
    logic [N-1:0] level1, press1, rel1;
    logic         tick1;

    btn_debounce #(.N_BTN(N), .DEB_MS(1), .INV_IN(1'b0)) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_1ms     (clk_1ms),
        .btn_raw     (raw1),
        .btn_level   (level1),
        .btn_press   (press1),
        .btn_release (rel1),
        .tick_1ms    (tick1)
    );

    // ---------------- scoreboard state ----------------
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    // event = {cycle[25:0], instance, is_release, button[3:0]}, kept sorted
    logic [31:0] exp_q[$];
    logic [31:0] ev;
    logic [N-1:0] exp_lvl [2];
    logic [N-1:0] ep [2];
    logic [N-1:0] er [2];
    logic        exp_tick;

    typedef struct {
        logic [N-1:0] raw;
        int           hold;
        logic [N-1:0] lvl;
    } vec_t;
    vec_t vecs [6];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, want);
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            clk_1ms = ((cyc % PER) >= PER / 2);
        end
    endtask

    // Cycle in which a clean change driven in cycle c shows up on the outputs:
    // it is in the WAIT state from c+3, the deb-th tick seen there accepts it,
    // and the registered result appears one cycle after that tick.
    function automatic int pred(input int c, input int deb);
        int t;
        t = c + 3;
        while ((t % PER) != TICK_PH) t++;
        return t + PER * (deb - 1) + 1;
    endfunction

    task automatic push_ev(input int c, input bit inst, input bit rel, input int b);
        logic [31:0] e;
        int          i;
        e = {c[25:0], inst, rel, b[3:0]};
        i = 0;
        while (i < exp_q.size() && exp_q[i] < e) i++;
        exp_q.insert(i, e);
    endtask

    task automatic drive0(input logic [N-1:0] nv);
        for (int b = 0; b < N; b++)
            if (nv[b] != btn_raw[b]) push_ev(pred(cyc, DEB), 1'b0, !nv[b], b);
        btn_raw = nv;
    endtask

    task automatic drive1(input logic [N-1:0] nv);
        for (int b = 0; b < N; b++)
            if (nv[b] != raw1[b]) push_ev(pred(cyc, 1), 1'b1, !nv[b], b);
        raw1 = nv;
    endtask

    task automatic wait_phase(input int ph);
        while ((cyc % PER) != ph) step(1);
    endtask

    // ---------------- monitor: pop expected events as their cycle arrives ----------------
    always @(negedge clk) begin
        ep[0] = '0; ep[1] = '0; er[0] = '0; er[1] = '0;
        if (!rst_n) begin
            exp_q.delete();
            exp_lvl[0] = '0;
            exp_lvl[1] = '0;
        end
        while (exp_q.size() > 0) begin
            ev = exp_q[0];
            if (int'(ev[31:6]) > cyc) break;
            void'(exp_q.pop_front());
            if (ev[4]) begin
                er[ev[5]][ev[3:0]]      = 1'b1;
                exp_lvl[ev[5]][ev[3:0]] = 1'b0;
            end else begin
                ep[ev[5]][ev[3:0]]      = 1'b1;
                exp_lvl[ev[5]][ev[3:0]] = 1'b1;
            end
        end
        exp_tick = rst_n && ((cyc % PER) == TICK_PH);
        chk("tick",     32'(tick_1ms),    32'(exp_tick));
        chk("press",    32'(btn_press),   32'(ep[0]));
        chk("release",  32'(btn_release), 32'(er[0]));
        chk("level",    32'(btn_level),   32'(exp_lvl[0]));
        chk("tick1",    32'(tick1),       32'(exp_tick));
        chk("press1",   32'(press1),      32'(ep[1]));
        chk("release1", 32'(rel1),        32'(er[1]));
        chk("level1",   32'(level1),      32'(exp_lvl[1]));
    end

    // ---------------- test sequence ----------------
    initial begin
        vecs[0] = '{raw: 4'b0001, hold: 200, lvl: 4'b0001}; // clean press, long hold
        vecs[1] = '{raw: 4'b0000, hold: 80,  lvl: 4'b0000};
        vecs[2] = '{raw: 4'b0101, hold: 80,  lvl: 4'b0101}; // 0 and 2 together
        vecs[3] = '{raw: 4'b0001, hold: 80,  lvl: 4'b0001}; // release 2 only
        vecs[4] = '{raw: 4'b1010, hold: 80,  lvl: 4'b1010}; // mixed press/release
        vecs[5] = '{raw: 4'b0000, hold: 80,  lvl: 4'b0000};

        // Reset spanning a full clk_1ms rise and fall, released in the low phase
        #2 rst_n = 1'b0;
        step(22);
        chk("reset_outputs", 32'({btn_level, btn_press, btn_release, tick_1ms}), 32'd0);
        rst_n = 1'b1;
        step(10);

        // Table-driven main function
        for (int k = 0; k < 6; k++) begin
            drive0(vecs[k].raw);
            step(vecs[k].hold);
            chk("vec_level", 32'(btn_level), 32'(vecs[k].lvl));
        end

        // Bounce on button 1: 15 clk high / 15 clk low, never accepted
        for (int k = 0; k < 7; k++) begin
            btn_raw[1] = (k % 2 == 0);
            step(15);
        end
        btn_raw[1] = 1'b0;
        step(80);
        chk("bounce_level", 32'(btn_level), 32'd0);

        // DEB_MS = 1: accepted on first tick after synchronisation
        wait_phase(0);
        drive1(4'b0001);
        step(60);
        chk("deb1_press_level", 32'(level1), 32'b0001);
        // High only between ticks: rejected
        wait_phase(14);
        raw1[1] = 1'b1;
        step(5);
        raw1[1] = 1'b0;
        step(40);
        chk("deb1_between_ticks", 32'(level1), 32'b0001);
        // Drops exactly in the tick cycle: bounce wins
        wait_phase(5);
        raw1[2] = 1'b1;
        step(5);
        raw1[2] = 1'b0;
        step(40);
        chk("deb1_bounce_on_tick", 32'(level1), 32'b0001);
        drive1(4'b0000);
        step(60);
        chk("deb1_release_level", 32'(level1), 32'd0);

        // Reset while button 3 is in WAIT_HI with cnt = 2 (button 0 held high)
        drive0(4'b0001);
        step(80);
        wait_phase(0);
        drive0(4'b1001);
        step(40);
        rst_n = 1'b0;
        #1;
        chk("rst_async_level",   32'(btn_level),   32'd0);
        chk("rst_async_press",   32'(btn_press),   32'd0);
        chk("rst_async_release", 32'(btn_release), 32'd0);
        step(5);
        rst_n = 1'b1;
        // Both held buttons are re-debounced from scratch
        push_ev(pred(cyc, DEB), 1'b0, 1'b0, 0);
        push_ev(pred(cyc, DEB), 1'b0, 1'b0, 3);
        step(80);
        chk("rst_redebounce_level", 32'(btn_level), 32'b1001);
        drive0(4'b0000);
        step(80);
        chk("final_level", 32'(btn_level), 32'd0);

        step(5);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
